// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: single-cycle logic/shift/compare ops, iterative
// shift-add multiply and restoring divide. Divider is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUcontrol_In,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_REM   = 4'b1111;

  logic [1:0]         state;
  logic [SHW-1:0]     cnt;
  logic [3:0]         op_r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;

  logic               accept;
  logic               go_mul;
  logic               go_div;
  logic               is_multi;
  logic [WIDTH-1:0]   fast_res;
  logic [SHW-1:0]     shamt;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               fin;
  logic [WIDTH-1:0]   fin_res;

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign shamt     = B[SHW-1:0];
  assign is_multi  = go_mul || go_div;
  assign last_iter = (cnt == SHW'(WIDTH - 1));

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic             in_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_d;
  logic             div_neg_q;
  logic             div_neg_r;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] div_q_fin;
  logic [WIDTH-1:0] div_r_fin;

  assign in_signed = (ALUcontrol_In == OP_DIV) || (ALUcontrol_In == OP_REM);
  assign abs_a     = (in_signed && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (in_signed && B[WIDTH-1]) ? -B : B;

  // Restoring step: the W+1 bit trial borrows (MSB set) exactly when the divisor does not fit.
  assign div_trial    = {div_rem, div_quo[WIDTH-1]} - {1'b0, div_d};
  assign div_ge       = !div_trial[WIDTH];
  assign div_rem_next = div_ge ? div_trial[WIDTH-1:0] : {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
  assign div_quo_next = {div_quo[WIDTH-2:0], div_ge};
  assign div_q_fin    = div_neg_q ? -div_quo_next : div_quo_next;
  assign div_r_fin    = div_neg_r ? -div_rem_next : div_rem_next;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    fast_res = '0;
    go_mul   = 1'b0;
    go_div   = 1'b0;
    case (ALUcontrol_In)
      OP_ADD:   fast_res = A + B;
      OP_SUB:   fast_res = A - B;
      OP_AND:   fast_res = A & B;
      OP_OR:    fast_res = A | B;
      OP_XOR:   fast_res = A ^ B;
      OP_SLL:   fast_res = A << shamt;
      OP_SRL:   fast_res = A >> shamt;
      OP_SRA:   fast_res = $signed(A) >>> shamt;
      OP_SLT:   fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MUL,
      OP_MULHU: go_mul = 1'b1;
      OP_DIVU,
      OP_REMU,
      OP_DIV,
      OP_REM: begin
`ifdef ALU_SEQ_DIV_EN
        // Divide-by-zero and signed overflow never enter the iterative divider.
        if (B == '0) begin
          fast_res = ((ALUcontrol_In == OP_DIVU) || (ALUcontrol_In == OP_DIV)) ? '1 : A;
        end else if (in_signed && (A == MOST_NEG) && (B == '1)) begin
          fast_res = (ALUcontrol_In == OP_DIV) ? A : '0;
        end else begin
          go_div = 1'b1;
        end
`else
        fast_res = '0;
`endif
      end
      default:  fast_res = '0;
    endcase
  end

  always_comb begin
    fin     = 1'b0;
    fin_res = '0;
    if ((state == S_MUL) && last_iter) begin
      fin     = 1'b1;
      fin_res = (op_r == OP_MUL) ? prod_next[WIDTH-1:0] : prod_next[2*WIDTH-1:WIDTH];
    end
`ifdef ALU_SEQ_DIV_EN
    if ((state == S_DIV) && last_iter) begin
      fin     = 1'b1;
      fin_res = ((op_r == OP_DIVU) || (op_r == OP_DIV)) ? div_q_fin : div_r_fin;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_r      <= '0;
      prod      <= '0;
      mcand     <= '0;
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_rem   <= '0;
      div_quo   <= '0;
      div_d     <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of order.
      if (fin) begin
        out_valid <= 1'b1;
        Result    <= fin_res;
        Zero      <= (fin_res == '0);
      end else if (accept && !is_multi) begin
        out_valid <= 1'b1;
        Result    <= fast_res;
        Zero      <= (fast_res == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept && go_mul) begin
            state <= S_MUL;
            cnt   <= '0;
            op_r  <= ALUcontrol_In;
            mcand <= A;
            prod  <= {{WIDTH{1'b0}}, B};
          end
`ifdef ALU_SEQ_DIV_EN
          else if (accept && go_div) begin
            state     <= S_DIV;
            cnt       <= '0;
            op_r      <= ALUcontrol_In;
            div_rem   <= '0;
            div_quo   <= abs_a;
            div_d     <= abs_b;
            div_neg_q <= in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            div_neg_r <= in_signed && A[WIDTH-1];
          end
`endif
        end
        S_MUL: begin
          prod <= prod_next;
          cnt  <= cnt + SHW'(1);
          if (last_iter) state <= S_IDLE;
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          div_rem <= div_rem_next;
          div_quo <= div_quo_next;
          cnt     <= cnt + SHW'(1);
          if (last_iter) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); divide expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUcontrol_In;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (A),
    .B             (B),
    .ALUcontrol_In (ALUcontrol_In),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .Result        (Result),
    .Zero          (Zero),
    .busy          (busy)
  );

  // Present one request for exactly one edge; caller guarantees in_ready is high.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUcontrol_In = op;
    A             = a;
    B             = b;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int budget, output int lat);
    lat = 0;
    while (!out_valid && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, Zero, busy, in_ready, Result} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL reset_state got v=%b z=%b busy=%b rdy=%b res=%h exp v=0 z=0 busy=0 rdy=1 res=0",
               out_valid, Zero, busy, in_ready, Result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got v=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  // Back-to-back single-cycle ops with out_ready held high: one result per edge.
  task automatic test_single_cycle();
    vec_t v[$];
    v.push_back('{4'b0000, 32'd10,        32'd5,        32'd15});
    v.push_back('{4'b0001, 32'd10,        32'd10,       32'd0});
    v.push_back('{4'b0010, 32'h0000F0F0,  32'h0000FF00, 32'h0000F000});
    v.push_back('{4'b0011, 32'h0000F0F0,  32'h0000FF00, 32'h0000FFF0});
    v.push_back('{4'b0100, 32'h0000F0F0,  32'h0000FF00, 32'h00000FF0});
    v.push_back('{4'b0101, 32'h00000001,  32'd31,       32'h80000000});
    v.push_back('{4'b0101, 32'h00000001,  32'd35,       32'h00000008});
    v.push_back('{4'b0110, 32'h80000000,  32'd4,        32'h08000000});
    v.push_back('{4'b0111, 32'hFFFFFFF8,  32'd33,       32'hFFFFFFFC});
    v.push_back('{4'b0111, 32'h80000000,  32'd31,       32'hFFFFFFFF});
    v.push_back('{4'b1000, 32'd3,         32'd5,        32'd1});
    v.push_back('{4'b1000, 32'd5,         32'd3,        32'd0});
    v.push_back('{4'b1000, 32'hFFFFFFFF,  32'd1,        32'd1});
    v.push_back('{4'b1001, 32'hFFFFFFFF,  32'd1,        32'd0});
    v.push_back('{4'b1001, 32'd1,         32'hFFFFFFFF, 32'd1});
    v.push_back('{4'b0000, 32'hFFFFFFFF,  32'd1,        32'd0});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, Zero, Result} !== {1'b1, (v[i].r == 32'd0), v[i].r}) begin
        failures++;
        $display("FAIL single_op%0d op=%b got v=%b z=%b res=%h exp v=1 z=%b res=%h",
                 i, v[i].op, out_valid, Zero, Result, (v[i].r == 32'd0), v[i].r);
      end
    end
  endtask

  task automatic test_mul();
    int lat;
    int bad;
    drain();
    issue(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (!busy || in_ready || out_valid) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mulhu_busy_window got %0d bad cycles exp 0", bad);
    end
    checks++;
    if ({out_valid, busy, Zero, Result} !== {1'b1, 1'b0, 1'b0, 32'hFFFFFFFE}) begin
      failures++;
      $display("FAIL mulhu_result got v=%b busy=%b z=%b res=%h exp v=1 busy=0 z=0 res=fffffffe",
               out_valid, busy, Zero, Result);
    end
    issue(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(40, lat);
    checks++;
    if (lat != 32 || Result !== 32'h00000001) begin
      failures++;
      $display("FAIL mul_low got lat=%0d res=%h exp lat=32 res=00000001", lat, Result);
    end
    issue(4'b1010, 32'd6, 32'd7);
    wait_result(40, lat);
    checks++;
    if (lat != 32 || Result !== 32'd42) begin
      failures++;
      $display("FAIL mul_small got lat=%0d res=%h exp lat=32 res=0000002a", lat, Result);
    end
    issue(4'b1011, 32'h80000000, 32'd4);
    wait_result(40, lat);
    checks++;
    if (lat != 32 || Result !== 32'd2) begin
      failures++;
      $display("FAIL mulhu_small got lat=%0d res=%h exp lat=32 res=00000002", lat, Result);
    end
  endtask

  task automatic test_div();
    int lat;
`ifdef ALU_SEQ_DIV_EN
    vec_t it[$];
    vec_t fp[$];
    it.push_back('{4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD});
    it.push_back('{4'b1111, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF});
    it.push_back('{4'b1100, 32'd100,      32'd7, 32'd14});
    it.push_back('{4'b1101, 32'd100,      32'd7, 32'd2});
    it.push_back('{4'b1110, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD});
    it.push_back('{4'b1111, 32'd7,        32'hFFFFFFFE, 32'd1});
    fp.push_back('{4'b1100, 32'd123,      32'd0, 32'hFFFFFFFF});
    fp.push_back('{4'b1111, 32'd5,        32'd0, 32'd5});
    fp.push_back('{4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    fp.push_back('{4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'd0});
    drain();
    foreach (it[i]) begin
      issue(it[i].op, it[i].a, it[i].b);
      wait_result(40, lat);
      checks++;
      if (lat != 32 || Result !== it[i].r || Zero !== (it[i].r == 32'd0)) begin
        failures++;
        $display("FAIL div_iter%0d op=%b got lat=%0d res=%h z=%b exp lat=32 res=%h",
                 i, it[i].op, lat, Result, Zero, it[i].r);
      end
    end
    foreach (fp[i]) begin
      issue(fp[i].op, fp[i].a, fp[i].b);
      checks++;
      if ({out_valid, busy, Zero, Result} !== {1'b1, 1'b0, (fp[i].r == 32'd0), fp[i].r}) begin
        failures++;
        $display("FAIL div_fast%0d op=%b got v=%b busy=%b z=%b res=%h exp v=1 busy=0 res=%h",
                 i, fp[i].op, out_valid, busy, Zero, Result, fp[i].r);
      end
    end
`else
    drain();
    issue(4'b1100, 32'd10, 32'd2);
    checks++;
    if ({out_valid, busy, Zero, Result} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL divu_disabled got v=%b busy=%b z=%b res=%h exp v=1 busy=0 z=1 res=0",
               out_valid, busy, Zero, Result);
    end
    issue(4'b0000, 32'd1, 32'd1);
    issue(4'b1111, 32'hFFFFFFF9, 32'd2);
    checks++;
    if ({out_valid, busy, Zero, Result} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL rem_disabled got v=%b busy=%b z=%b res=%h exp v=1 busy=0 z=1 res=0",
               out_valid, busy, Zero, Result);
    end
    lat = 0;
`endif
  endtask

  task automatic test_backpressure();
    int bad;
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'b0000, 32'd3, 32'd4);
    checks++;
    if ({out_valid, Result} !== {1'b1, 32'd7}) begin
      failures++;
      $display("FAIL bp_first got v=%b res=%h exp v=1 res=00000007", out_valid, Result);
    end
    @(negedge clk);
    ALUcontrol_In = 4'b0000;
    A             = 32'd1;
    B             = 32'd1;
    in_valid      = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if ({out_valid, in_ready, Zero, Result} !== {1'b1, 1'b0, 1'b0, 32'd7}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d bad cycles exp 0 (res=%h rdy=%b)", bad, Result, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Result} !== {1'b1, 32'd2}) begin
      failures++;
      $display("FAIL bp_release got v=%b res=%h exp v=1 res=00000002", out_valid, Result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_consume got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    drain();
    issue(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, Zero, Result} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL midmul_reset got v=%b busy=%b rdy=%b z=%b res=%h exp 0 0 1 0 0",
               out_valid, busy, in_ready, Zero, Result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL midmul_no_result got v=%b busy=%b exp 0 0", out_valid, busy);
    end
    issue(4'b0000, 32'd1, 32'd1);
    checks++;
    if ({out_valid, Zero, Result} !== {1'b1, 1'b0, 32'd2}) begin
      failures++;
      $display("FAIL midmul_after_add got v=%b z=%b res=%h exp v=1 z=0 res=00000002",
               out_valid, Zero, Result);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    A             = '0;
    B             = '0;
    ALUcontrol_In = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle 32-bit ALU.
- Adds a valid/ready handshake on both sides, WIDTH-generic datapath, SLTU, and iterative multiply/divide run by an FSM.
- Sits between the decode/issue stage and writeback.
- Single-cycle ops complete in 1 cycle; MUL/DIV ops take WIDTH cycles.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8. Local SHW = $clog2(WIDTH) is the shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount.
- ALUcontrol_In  in  4  opcode.
- out_valid  out  1  Result/Zero hold a valid result.
- out_ready  in  1  consumer takes the result.
- Result  out  WIDTH  registered result.
- Zero  out  1  registered (Result == 0).
- busy  out  1  iterative op in progress.

Behaviour:
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL; 0110 SRL; 0111 SRA; 1000 SLT (signed).
  - 1001 SLTU.
  - 1010 MUL (low WIDTH bits); 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIVU; 1101 REMU; 1110 DIV; 1111 REM (signed, quotient truncated toward zero).
- Reset (async, any state incl. mid-iteration): state=IDLE, out_valid=0, Result=0, Zero=0, busy=0, internal regs cleared. Aborted op produces no result.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Acceptance = in_valid && in_ready at a rising edge. A, B and opcode are captured then and may change afterward. in_valid with in_ready=0 is ignored; the requester must hold it.
- Single-cycle ops (0000–1001): Result/Zero/out_valid=1 written at the accepting edge.
- Output hold: out_valid stays 1 with Result/Zero stable until an edge with out_ready=1. Then out_valid clears, unless a new single-cycle op is accepted at the same edge, in which case it is back-to-back and out_valid stays 1 with new data.
- States: IDLE, MUL, DIV.
  - IDLE -> MUL on accepting 1010/1011; IDLE -> DIV on accepting 1100–1111.
  - MUL: radix-2 shift-add on unsigned operands, 2*WIDTH product register, counter 0..WIDTH-1.
  - DIV: restoring division on operand magnitudes, WIDTH iterations. Signed ops fix quotient/remainder signs at completion; remainder takes the sign of A.
  - On the WIDTH-th edge after acceptance: Result, Zero and out_valid=1 written, state -> IDLE.
- busy = (state != IDLE).
- Fast paths (DIV* only), completed at the accepting edge like a single-cycle op, no DIV state entered:
  - B==0: DIVU/DIV -> all ones; REMU/REM -> A.
  - DIV/REM with A = most-negative and B = all ones: DIV -> A, REM -> 0.
- All arithmetic is modulo 2^WIDTH; no overflow flags.
- Shifts use only B[SHW-1:0].

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: opcodes 1100–1111 behave as above; DIV state and divider datapath are present.
- Undefined: divider logic is not built. Opcodes 1100–1111 complete as single-cycle ops with Result=0, Zero=1. MUL/MULHU unaffected.

Test Plan:
- Reset then ADD A=10,B=5, out_ready=1 -> out_valid next edge, Result=15, Zero=0; SUB 10-10 -> Result=0, Zero=1.
- SRA A=-8,B=33 (shamt 1) -> Result=-4 (0xFFFFFFFC); SLT 3,5 -> 1; SLTU A=0xFFFFFFFF,B=1 -> 0.
- MULHU A=0xFFFFFFFF,B=0xFFFFFFFF -> in_ready=0 and busy=1 for 32 cycles, then Result=0xFFFFFFFE. MUL same operands -> 0x00000001.
- DIV A=-7,B=2 -> Result=-3; REM -> -1. DIVU by B=0 -> 0xFFFFFFFF after 1 cycle. DIV A=0x80000000,B=-1 -> 0x80000000.
- Backpressure: out_ready=0 for 5 cycles after ADD result -> Result stable, in_ready=0, next in_valid not accepted until out_ready=1.
- Assert rst at iteration 10 of MUL -> out_valid=0, Result=0, in_ready=1 immediately. Subsequent ADD 1+1 -> 2. Without ALU_SEQ_DIV_EN: DIVU 10,2 -> Result=0, Zero=1 in 1 cycle.
